// File: rtl/bcd_display_ctrl.sv
// Serial shift-and-add-3 binary-to-BCD converter driving a multiplexed 8-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining BCD_DISPLAY_CTRL_LZ_BLANK_EN.
module bcd_display_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int NDIG     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [31:0] bcd_out,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int IDX_W = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg;
  logic [31:0] shreg_reg;
  logic [39:0] scratch_reg;
  logic [4:0]  bit_cnt_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ovf_reg;
  logic [31:0] bcd_reg;

  logic [39:0] scratch_adj;
  logic [39:0] scratch_next;
  logic [31:0] shreg_next;

  // Add-3 correction on every scratch nibble before the shift.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_adj
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                      scratch_reg[4*gi +: 4] + 4'd3 :
                                      scratch_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    {scratch_next, shreg_next} = {scratch_adj, shreg_reg} << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      scratch_reg <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      bcd_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (load) begin
            shreg_reg   <= bin;
            scratch_reg <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          shreg_reg   <= shreg_next;
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          // Result is captured from the final shift so done lands in the DONE cycle.
          if (bit_cnt_reg == 5'd31) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            if (scratch_next[39:32] != 8'd0) begin
              bcd_reg <= 32'h9999_9999;
              ovf_reg <= 1'b1;
            end else begin
              bcd_reg <= scratch_next[31:0];
              ovf_reg <= 1'b0;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ovf     = ovf_reg;
  assign bcd_out = bcd_reg;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [NDIG-1:0] blank_mask;

`ifdef BCD_DISPLAY_CTRL_LZ_BLANK_EN
  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_blank
      assign blank_mask[gi] = (gi != 0) && (bcd_reg[31:4*gi] == '0);
    end
  endgenerate
`else
  assign blank_mask = '0;
`endif

  logic [15:0]      scan_cnt_reg;
  logic             wrap_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       an_reg;
  logic [6:0]       seg_reg;

  logic [3:0] cur_digit;
  logic [6:0] seg_next;

  assign cur_digit = bcd_reg[4*idx_reg +: 4];
  assign seg_next  = blank_mask[idx_reg] ? 7'h7F : seg_decode(cur_digit);

  // The pins follow one cycle after each counter wrap, then the index advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      wrap_reg     <= 1'b0;
      idx_reg      <= '0;
      an_reg       <= 8'hFF;
      seg_reg      <= 7'h7F;
    end else begin
      if (scan_cnt_reg == 16'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        wrap_reg     <= 1'b1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 16'd1;
        wrap_reg     <= 1'b0;
      end
      if (wrap_reg) begin
        an_reg  <= ~(8'b1 << idx_reg);
        seg_reg <= seg_next;
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: directed and random conversions against an
// arithmetic decimal model, plus scan-order and segment checks with a short scan period.
module tb_bcd_display_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] bin = '0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] bcd_out;
  logic [7:0]  an;
  logic [6:0]  seg;

  bcd_display_ctrl #(.SCAN_DIV(SCAN_DIV), .NDIG(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cur_val = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned shown(input int unsigned v);
    return (v > 32'd99999999) ? 32'd99999999 : v;
  endfunction

  function automatic logic [31:0] model_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    x = shown(v);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned v, input int d);
    int unsigned p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
`ifdef BCD_DISPLAY_CTRL_LZ_BLANK_EN
    if (d > 0 && v < p) return 7'h7F;
`endif
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic convert(input int unsigned v);
    int n;
    bit busy_ok;
    bin = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd32);
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("bcd_out", bcd_out, model_bcd(v));
    check("ovf", {31'd0, ovf}, {31'd0, (v > 32'd99999999)});
    $display("convert bin=%0d -> bcd_out=%h ovf=%0b cycles=%0d", v, bcd_out, ovf, n);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    cur_val = shown(v);
  endtask

  task automatic scan_check(input int nupd);
    int prev;
    int n;
    int idx;
    logic [7:0] an_prev;
    prev = -1;
    for (int u = 0; u < nupd; u++) begin
      an_prev = an;
      n = 0;
      while (an == an_prev && n < 3 * SCAN_DIV) begin
        tick();
        n++;
      end
      idx = 0;
      for (int b = 0; b < 8; b++) if (!an[b]) idx = b;
      check("an_onehot", $countones(~an), 32'd1);
      if (prev >= 0) begin
        check("scan_period", 32'(n), 32'(SCAN_DIV));
        check("scan_order", 32'(idx), 32'((prev + 1) % 8));
      end
      check("seg", {25'd0, seg}, {25'd0, model_seg(cur_val, idx)});
      $display("scan val=%0d an=%h seg=%h", cur_val, an, seg);
      prev = idx;
    end
  endtask

  initial begin
    int n;
    int ndone;
    int nbusy;
    int unsigned v;
    int unsigned dir_vals [12] = '{1234, 1, 10, 100, 9999, 1555, 1802,
                                   32'hFFFF_FFFF, 99999999, 100000000, 0, 87654321};

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_bcd", bcd_out, 32'd0);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    $display("reset: busy=%0b done=%0b an=%h seg=%h", busy, done, an, seg);

    rst_n = 1'b1;
    n = 0;
    while (an == 8'hFF && n < 20) begin
      tick();
      n++;
    end
    check("first_lit_delay", 32'(n), 32'(SCAN_DIV + 1));
    check("first_lit_an", {24'd0, an}, 32'hFE);
    check("first_lit_seg", {25'd0, seg}, {25'd0, model_seg(0, 0)});
    $display("first digit after %0d cycles an=%h seg=%h", n, an, seg);

    foreach (dir_vals[i]) convert(dir_vals[i]);

    for (int i = 0; i < 16; i++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99999999);
      convert(v);
    end

    // Load while busy is ignored.
    bin = 1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 5) begin
        bin = 9999;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      if (done) ndone++;
    end
    load = 1'b0;
    check("busy_load_done_cnt", 32'(ndone), 32'd1);
    check("busy_load_bcd", bcd_out, 32'h0000_1234);
    $display("load while busy: done pulses=%0d bcd_out=%h", ndone, bcd_out);
    cur_val = 1234;

    // Reset in the middle of a conversion.
    bin = 1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check("midrst_done_cnt", 32'(ndone), 32'd0);
    check("midrst_busy_cnt", 32'(nbusy), 32'd0);
    check("midrst_bcd", bcd_out, 32'd0);
    $display("reset mid-conversion: done pulses=%0d busy cycles=%0d bcd_out=%h", ndone, nbusy, bcd_out);
    cur_val = 0;

    convert(87654321);
    scan_check(10);
    convert(1234);
    scan_check(9);
    convert(0);
    scan_check(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
- Sequencing controller for the 8-digit binary-to-BCD path feeding the board's multiplexed 7-segment display.
- Accepts a 32-bit binary value with a load strobe and converts it serially by shift-and-add-3 over 32 iterations.
- Holds the result in a double-buffered BCD register, then time-multiplexes the 8 digits onto active-low anode and segment lines.
- Sits between the application logic that produces binary counts and the display pins.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is lit; legal range 2..65535.
- NDIG, 8: number of displayed digits; fixed at 8, present for documentation only.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- load  in  1  one-cycle request to convert bin; honoured only when busy=0.
- bin  in  32  unsigned binary value, sampled on an accepted load.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd_out and ovf are updated in the same cycle.
- ovf  out  1  high when the last converted value exceeded 99999999.
- bcd_out  out  32  8 packed BCD digits; digit 0 is bits [3:0].
- an  out  8  anode enables, active low, one-hot-zero.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - outputs: busy=0, done=0, ovf=0, bcd_out=0, an=8'hFF, seg=7'h7F.
  - internal state: state=IDLE, scan counter=0, digit index=0.
  - A reset mid-conversion aborts it; bcd_out stays 0 and no done pulse is issued.
- Conversion FSM states:
  - IDLE: on load=1, latch bin into a shift register, clear a 40-bit (10-digit) scratch register, clear the bit counter, go to SHIFT, set busy=1 from the next cycle.
  - SHIFT: each cycle, first add 3 to every scratch nibble >=5, then shift {scratch, shreg} left by 1 and increment the bit counter. After the 32nd shift, go to DONE.
  - DONE: for one cycle, assert done=1 and busy=0.
    - If scratch[39:32]!=0: bcd_out=32'h99999999 and ovf=1 (saturate).
    - Otherwise: bcd_out=scratch[31:0] and ovf=0.
    - Return to IDLE.
- Latency: load sampled at edge N, busy=1 for edges N+1..N+32, done=1 at edge N+33. A new load is accepted in that same DONE cycle's successor (the IDLE cycle).
- load while busy=1 (SHIFT or DONE) is ignored, with no queueing.
- bcd_out and ovf change only in DONE; the display keeps showing the previous value throughout a conversion.
- Scanner (runs independently of the FSM, continuously after reset):
  - A 16-bit counter counts 0..SCAN_DIV-1 and wraps.
  - On each wrap, the digit index increments 0..7 and wraps to 0.
  - an and seg are registered and take effect one cycle after the index changes: an=~(8'b1<<idx), seg=decode(bcd_out[4*idx+:4]).
  - First digit lit: digit 0, SCAN_DIV+1 cycles after reset release.
- Decode values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, 7-bit). Codes 10..15 decode to blank (7F).
- done and an/seg updates occurring in the same cycle: seg uses the bcd_out value registered before that edge, and shows the new value from the next scan update.

Optional Feature:
- Macro: BCD_DISPLAY_CTRL_LZ_BLANK_EN.
- Defined: leading-zero blanking. Any digit above the most significant nonzero digit shows seg=7F while its anode is still driven. Digit 0 is never blanked, so value 0 shows a single "0". Blanking mask is computed from bcd_out.
- Undefined: all 8 digits are displayed, including leading zeros.

Test Plan:
- Basic conversion: reset, load bin=1234 (0x4D2) -> busy high 32 cycles; done at load+33 with bcd_out=32'h00001234, ovf=0.
- Sweep: bin=1, 10, 100, 9999, 1555, 1802 -> bcd_out=0x1, 0x10, 0x100, 0x9999, 0x1555, 0x1802 respectively.
- Overflow: bin=32'hFFFFFFFF -> bcd_out=32'h99999999, ovf=1. Then bin=99999999 -> same bcd_out, ovf=0.
- Load while busy and reset mid-operation:
  - Load 1234, then load 9999 at load+5 -> only one done pulse, bcd_out=0x1234.
  - Repeat the 1234 load with rst_n=0 at load+10 -> no done pulse, bcd_out=0, busy=0.
- Scan with SCAN_DIV=4 and bcd_out=0x87654321 -> an steps FE,FD,FB,...,7F every 4 cycles, seg=79,24,30,19,12,02,78,00, wraps to FE.
- With BCD_DISPLAY_CTRL_LZ_BLANK_EN: bcd_out=0x00001234 -> digits 4-7 seg=7F. bcd_out=0 -> digit 0 seg=40, others 7F.
